// File: rtl/bootram_bus_adapter.sv
// PicoRV32 native bus to 1K x 32 single-port boot RAM adapter.
// Handles reads, full-word stores and read-modify-write for byte stores,
// since the RAM has no byte enables and a one-cycle registered read.
module bootram_bus_adapter #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter bit          WRITE_PROTECT = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic [31:0]           mem_addr,
    input  logic [3:0]            mem_wstrb,
    input  logic [31:0]           mem_wdata,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic                  wr_err,
    output logic                  bram_ce,
    output logic                  bram_oce,
    output logic                  bram_wre,
    output logic [ADDR_WIDTH-1:0] bram_ad,
    output logic [31:0]           bram_din,
    input  logic [31:0]           bram_dout
);

    typedef enum logic [1:0] {StIdle, StRdWait, StRmw, StAck} state_e;

    state_e      state_q, state_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] merged;
    logic        is_read;
    logic        is_full;

    // Address bits outside the RAM window are deliberately ignored (aliasing).
    logic unused_addr;
    assign unused_addr = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

    assign is_read  = (mem_wstrb == 4'b0000);
    assign is_full  = (mem_wstrb == 4'b1111);
    assign bram_ad  = mem_addr[ADDR_WIDTH+1:2];
    assign bram_oce = 1'b1;

    // Byte merge of store data over the word just read from the RAM.
    always_comb begin
        merged = bram_dout;
        for (int i = 0; i < 4; i++) begin
            if (mem_wstrb[i]) begin
                merged[8*i +: 8] = mem_wdata[8*i +: 8];
            end
        end
    end

    // Next-state, registered-output next values and combinational RAM controls.
    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        bram_ce  = 1'b0;
        bram_wre = 1'b0;
        bram_din = mem_wdata;
        unique case (state_q)
            StIdle: begin
                if (mem_valid) begin
                    if (is_read) begin
                        bram_ce = 1'b1;
                        state_d = StRdWait;
                    end else if (WRITE_PROTECT) begin
                        // Store acknowledged but RAM never touched.
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        state_d = StAck;
                    end else if (is_full) begin
                        bram_ce  = 1'b1;
                        bram_wre = 1'b1;
                        ready_d  = 1'b1;
                        state_d  = StAck;
                    end else begin
                        // Partial store: fetch the old word first.
                        bram_ce = 1'b1;
                        state_d = StRmw;
                    end
                end
            end
            StRdWait: begin
                rdata_d = bram_dout;
                ready_d = 1'b1;
                state_d = StAck;
            end
            StRmw: begin
                bram_ce  = 1'b1;
                bram_wre = 1'b1;
                bram_din = merged;
                ready_d  = 1'b1;
                state_d  = StAck;
            end
            StAck: begin
                ready_d = 1'b0;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Reset must never let a RAM access through, even mid-transaction.
        if (reset) begin
            bram_ce  = 1'b0;
            bram_wre = 1'b0;
        end
    end

    // State and registered CPU-side outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_ready = ready_q;
    assign wr_err    = err_q;
    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_bootram_bus_adapter.sv
// Self-checking bench for bootram_bus_adapter: directed vector table, reset
// and write-protect sequences, then random back-to-back traffic checked
// against a word-array memory model.
module tb_bootram_bus_adapter;

    logic        clk = 1'b0;
    logic        reset;
    logic        main_valid, wp_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    logic        m_ready, m_err, m_ce, m_oce, m_wre;
    logic [31:0] m_rdata, m_din;
    logic [31:0] m_dout = 32'h0;
    logic [9:0]  m_ad;
    logic        w_ready, w_err, w_ce, w_oce, w_wre;
    logic [31:0] w_rdata, w_din;
    logic [31:0] w_dout = 32'h0;
    logic [9:0]  w_ad;

    logic [31:0] ram_m [1024];
    logic [31:0] ram_w [1024];
    logic [31:0] ref_mem [1024];
    int          m_wre_cnt = 0;
    int          w_wre_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    bootram_bus_adapter #(.ADDR_WIDTH(10), .WRITE_PROTECT(1'b0)) u_dut (
        .clk(clk), .reset(reset), .mem_valid(main_valid), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(m_ready),
        .mem_rdata(m_rdata), .wr_err(m_err), .bram_ce(m_ce), .bram_oce(m_oce),
        .bram_wre(m_wre), .bram_ad(m_ad), .bram_din(m_din), .bram_dout(m_dout)
    );

    bootram_bus_adapter #(.ADDR_WIDTH(10), .WRITE_PROTECT(1'b1)) u_dut_wp (
        .clk(clk), .reset(reset), .mem_valid(wp_valid), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(w_ready),
        .mem_rdata(w_rdata), .wr_err(w_err), .bram_ce(w_ce), .bram_oce(w_oce),
        .bram_wre(w_wre), .bram_ad(w_ad), .bram_din(w_din), .bram_dout(w_dout)
    );

    // Boot RAM models: 1-cycle registered read, whole-word write.
    always @(posedge clk) begin
        if (m_ce) begin
            if (m_wre) ram_m[m_ad] <= m_din;
            else       m_dout <= ram_m[m_ad];
        end
        if (w_ce) begin
            if (w_wre) ram_w[w_ad] <= w_din;
            else       w_dout <= ram_w[w_ad];
        end
        if (m_wre) m_wre_cnt <= m_wre_cnt + 1;
        if (w_wre) w_wre_cnt <= w_wre_cnt + 1;
    end

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_wre;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] store_merge(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // One CPU transaction; inputs change on negedges, outputs sampled on negedges.
    task automatic txn(input bit wp, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output int lat, output logic err, output int wres);
        int  w0;
        bit  rdy;
        w0        = wp ? w_wre_cnt : m_wre_cnt;
        mem_addr  = addr;
        mem_wstrb = strb;
        mem_wdata = wdata;
        if (wp) wp_valid = 1'b1;
        else    main_valid = 1'b1;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lat++;
            rdy = wp ? w_ready : m_ready;
            if (rdy) break;
        end
        rdata      = wp ? w_rdata : m_rdata;
        err        = wp ? w_err : m_err;
        main_valid = 1'b0;
        wp_valid   = 1'b0;
        @(negedge clk);
        check("single_ready_pulse", {31'h0, wp ? w_ready : m_ready}, 32'h0);
        check("wr_err_cleared", {31'h0, wp ? w_err : m_err}, 32'h0);
        wres = (wp ? w_wre_cnt : m_wre_cnt) - w0;
    endtask

    initial begin
        logic [31:0] rd, a, d;
        logic [3:0]  s;
        logic        e;
        int          lat, wres, sel, w0;

        for (int i = 0; i < 1024; i++) begin
            ram_m[i]   = 32'h0;
            ram_w[i]   = 32'h0;
            ref_mem[i] = 32'h0;
        end
        ram_m[0]   = 32'h0B00006F;
        ram_w[0]   = 32'h0B00006F;
        ref_mem[0] = 32'h0B00006F;

        tbl[0] = '{32'h0000_0000, 4'b0000, 32'h0,         32'h0B00006F, 2, 0};
        tbl[1] = '{32'h0000_0FFC, 4'b1111, 32'hDEADBEEF, 32'h0,        1, 1};
        tbl[2] = '{32'h0000_0FFC, 4'b0000, 32'h0,         32'hDEADBEEF, 2, 0};
        tbl[3] = '{32'h0000_0100, 4'b1111, 32'h11223344, 32'h0,        1, 1};
        tbl[4] = '{32'h0000_0100, 4'b0101, 32'hAABBCCDD, 32'h0,        2, 1};
        tbl[5] = '{32'h0000_0100, 4'b0000, 32'h0,         32'h11BB33DD, 2, 0};
        tbl[6] = '{32'h0000_1100, 4'b0000, 32'h0,         32'h11BB33DD, 2, 0};
        tbl[7] = '{32'h0000_2FFC, 4'b0000, 32'h0,         32'hDEADBEEF, 2, 0};
        tbl[8] = '{32'hFFFF_F004, 4'b1111, 32'hCAFEF00D, 32'h0,        1, 1};
        tbl[9] = '{32'h0000_0004, 4'b0000, 32'h0,         32'hCAFEF00D, 2, 0};

        // Reset with a pending read: RAM must stay disabled.
        reset      = 1'b1;
        main_valid = 1'b1;
        wp_valid   = 1'b0;
        mem_addr   = 32'h0;
        mem_wstrb  = 4'b0000;
        mem_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'h0, m_ready}, 32'h0);
        check("reset_rdata", m_rdata, 32'h0);
        check("reset_wr_err", {31'h0, m_err}, 32'h0);
        check("reset_ce", {31'h0, m_ce}, 32'h0);
        check("reset_wre", {31'h0, m_wre}, 32'h0);
        check("oce_const", {31'h0, m_oce}, 32'h1);
        main_valid = 1'b0;
        reset      = 1'b0;
        @(negedge clk);

        // Directed vectors.
        foreach (tbl[i]) begin
            txn(1'b0, tbl[i].addr, tbl[i].wstrb, tbl[i].wdata, rd, lat, e, wres);
            check($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
            check($sformatf("vec%0d_wre_cycles", i), wres, tbl[i].exp_wre);
            check($sformatf("vec%0d_wr_err", i), {31'h0, e}, 32'h0);
            if (tbl[i].wstrb == 4'b0000)
                check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
            else
                ref_mem[tbl[i].addr[11:2]] = store_merge(ref_mem[tbl[i].addr[11:2]],
                                                         tbl[i].wdata, tbl[i].wstrb);
        end

        // Reset asserted during the RMW cycle abandons the store.
        w0         = m_wre_cnt;
        mem_addr   = 32'h0000_0100;
        mem_wstrb  = 4'b0011;
        mem_wdata  = 32'h55555555;
        main_valid = 1'b1;
        @(negedge clk);
        reset      = 1'b1;
        main_valid = 1'b0;
        #1;
        check("rstrmw_wre_gated", {31'h0, m_wre}, 32'h0);
        check("rstrmw_ce_gated", {31'h0, m_ce}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        check("rstrmw_ready", {31'h0, m_ready}, 32'h0);
        check("rstrmw_rdata", m_rdata, 32'h0);
        check("rstrmw_wre_count", m_wre_cnt - w0, 32'h0);
        @(negedge clk);
        check("rstrmw_no_late_ready", {31'h0, m_ready}, 32'h0);
        txn(1'b0, 32'h0000_0100, 4'b0000, 32'h0, rd, lat, e, wres);
        check("rstrmw_readback", rd, 32'h11BB33DD);
        check("rstrmw_read_latency", lat, 2);

        // Write-protected instance.
        txn(1'b1, 32'h0000_0000, 4'b1111, 32'hFFFFFFFF, rd, lat, e, wres);
        check("wp_full_latency", lat, 1);
        check("wp_full_err", {31'h0, e}, 32'h1);
        txn(1'b1, 32'h0000_0040, 4'b0010, 32'h12345678, rd, lat, e, wres);
        check("wp_partial_latency", lat, 1);
        check("wp_partial_err", {31'h0, e}, 32'h1);
        txn(1'b1, 32'h0000_0000, 4'b0000, 32'h0, rd, lat, e, wres);
        check("wp_read_latency", lat, 2);
        check("wp_read_err", {31'h0, e}, 32'h0);
        check("wp_readback", rd, 32'h0B00006F);
        check("wp_wre_never", w_wre_cnt, 32'h0);

        // Random back-to-back traffic against the word-array model.
        for (int n = 0; n < 1000; n++) begin
            a   = $urandom;
            d   = $urandom;
            sel = $urandom_range(0, 2);
            s   = (sel == 0) ? 4'b0000 : (sel == 1) ? 4'b1111 : 4'($urandom_range(1, 14));
            txn(1'b0, a, s, d, rd, lat, e, wres);
            if (s == 4'b0000) begin
                check("rnd_read_data", rd, ref_mem[a[11:2]]);
                check("rnd_read_latency", lat, 2);
                check("rnd_read_wre", wres, 0);
            end else begin
                ref_mem[a[11:2]] = store_merge(ref_mem[a[11:2]], d, s);
                check("rnd_write_latency", lat, (s == 4'b1111) ? 1 : 2);
                check("rnd_write_wre", wres, 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
